// File: rtl/pool_collect.sv
// ============================================================================
//  Module      : pool_collect
//  Description : Collects the sparse max-pool output stream into a FIFO. Each
//                sample is tagged with its pooled row/col and an end-of-frame
//                flag, then re-emitted on a ready/valid stream to the FC layer.
//                Optional macro POOL_COLLECT_RELU_EN clamps negative samples to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_collect #(
    parameter int PP      = 8,
    parameter int DIM_OUT = 14,
    parameter int DEPTH   = 16,
    parameter int IW      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [PP:0]   pool_in,
    input  logic                 pool_valid,
    output logic signed [PP:0]   out_data,
    output logic [IW-1:0]        out_row,
    output logic [IW-1:0]        out_col,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int C_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CW = $clog2(DEPTH + 1);
    localparam int C_EW = 1 + 2 * IW + PP + 1;
    localparam logic [IW-1:0]   c_LAST_IDX = IW'(DIM_OUT - 1);
    localparam logic [C_CW-1:0] c_FULL_CNT = C_CW'(DEPTH);

    logic [C_EW-1:0] r_mem [DEPTH];
    logic [C_AW-1:0] r_wr_ptr;
    logic [C_AW-1:0] r_rd_ptr;
    logic [C_CW-1:0] r_count;
    logic [IW-1:0]   r_in_row;
    logic [IW-1:0]   r_in_col;
    logic            r_frame_done;
    logic            r_overflow;

    logic            w_full;
    logic            w_pop;
    logic            w_wr_en;
    logic            w_in_last;
    logic [PP:0]     w_wr_data;
    logic [C_EW-1:0] w_head;

    assign w_full    = (r_count == c_FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign w_wr_en   = pool_valid & (~w_full | w_pop);
    assign w_in_last = (r_in_row == c_LAST_IDX) && (r_in_col == c_LAST_IDX);

`ifdef POOL_COLLECT_RELU_EN
    assign w_wr_data = pool_in[PP] ? '0 : pool_in;
`else
    assign w_wr_data = pool_in;
`endif

    // Storage is reset so the head view reads all-zero while empty after reset.
    assign w_head = r_mem[r_rd_ptr];
    assign {out_last, out_row, out_col, out_data} = w_head;

    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_in_row     <= '0;
            r_in_col     <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= {w_in_last, r_in_row, r_in_col, w_wr_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                if (r_in_col == c_LAST_IDX) begin
                    r_in_col <= '0;
                    r_in_row <= (r_in_row == c_LAST_IDX) ? '0 : r_in_row + 1'b1;
                end else begin
                    r_in_col <= r_in_col + 1'b1;
                end
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_frame_done <= w_pop & out_last;

            if (pool_valid & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pool_collect.sv
// ============================================================================
//  Module      : tb_pool_collect
//  Description : Directed self-checking bench for pool_collect.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pool_collect;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [8:0] pool_in;
    logic              pool_valid;
    logic signed [8:0] out_data;
    logic [4:0]        out_row;
    logic [4:0]        out_col;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              frame_done;
    logic              overflow;

    int vectors    = 0;
    int miscompares = 0;

    pool_collect #(.PP(8), .DIM_OUT(14), .DEPTH(16), .IW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .pool_in    (pool_in),
        .pool_valid (pool_valid),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        pool_valid = 1'b0;
        pool_in    = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({out_valid, out_data, out_row, out_col, out_last, frame_done, overflow} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b d=%0d r=%0d c=%0d l=%b fd=%b ov=%b, want all 0",
                     out_valid, out_data, out_row, out_col, out_last, frame_done, overflow);
        end
    endtask

    task automatic test_single();
        apply_reset();
        pool_valid = 1'b1; pool_in = 9'sd5; out_ready = 1'b1;
        tick();
        pool_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 9'sd5 || out_row !== 5'd0 || out_col !== 5'd0) begin
            miscompares++;
            $display("FAIL single_head: got v=%b d=%0d r=%0d c=%0d, want v=1 d=5 r=0 c=0",
                     out_valid, out_data, out_row, out_col);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_frame();
        int bad = 0;
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 196; k++) begin
            pool_valid = 1'b1;
            pool_in    = 9'(k);
            tick();
            if (out_valid !== 1'b1 || out_data !== 9'(k) || out_row !== 5'(k / 14) ||
                out_col !== 5'(k % 14) || out_last !== (k == 195) || frame_done !== 1'b0) begin
                if (bad < 5)
                    $display("FAIL frame_sample %0d: got v=%b d=%0d r=%0d c=%0d l=%b fd=%b, want v=1 d=%0d r=%0d c=%0d l=%b fd=0",
                             k, out_valid, out_data, out_row, out_col, out_last, frame_done,
                             k, k / 14, k % 14, (k == 195));
                bad++;
            end
        end
        vectors++;
        if (bad != 0) miscompares++;
        pool_valid = 1'b0;
        tick();
        vectors++;
        if (frame_done !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_done_pulse: got fd=%b v=%b, want fd=1 v=0", frame_done, out_valid);
        end
        tick();
        vectors++;
        if (frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_done_width: got fd=%b, want 0", frame_done);
        end
        pool_valid = 1'b1; pool_in = 9'sd42;
        tick();
        pool_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_row !== 5'd0 || out_col !== 5'd0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_wrap: got v=%b r=%0d c=%0d l=%b, want v=1 r=0 c=0 l=0",
                     out_valid, out_row, out_col, out_last);
        end
    endtask

    task automatic test_overflow();
        int bad = 0;
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            pool_valid = 1'b1;
            pool_in    = 9'(100 + k);
            tick();
        end
        pool_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_flag: got v=%b ov=%b, want v=1 ov=1", out_valid, overflow);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (out_valid !== 1'b1 || out_data !== 9'(100 + k) ||
                out_row !== 5'(k / 14) || out_col !== 5'(k % 14)) begin
                if (bad < 5)
                    $display("FAIL overflow_pop %0d: got v=%b d=%0d r=%0d c=%0d, want v=1 d=%0d r=%0d c=%0d",
                             k, out_valid, out_data, out_row, out_col, 100 + k, k / 14, k % 14);
                bad++;
            end
            tick();
        end
        vectors++;
        if (bad != 0) miscompares++;
        vectors++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_drained: got v=%b ov=%b, want v=0 ov=1", out_valid, overflow);
        end
        // The dropped 17th sample must not have advanced the indices.
        pool_valid = 1'b1; pool_in = 9'sd1;
        tick();
        pool_valid = 1'b0;
        vectors++;
        if (out_row !== 5'd1 || out_col !== 5'd2) begin
            miscompares++;
            $display("FAIL overflow_index: got r=%0d c=%0d, want r=1 c=2", out_row, out_col);
        end
    endtask

    task automatic test_full_push_pop();
        int n = 0;
        logic signed [8:0] last_d = '0;
        logic [4:0] last_r = '0;
        logic [4:0] last_c = '0;
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            pool_valid = 1'b1;
            pool_in    = 9'(k);
            tick();
        end
        out_ready = 1'b1; pool_valid = 1'b1; pool_in = 9'sd77;
        tick();
        vectors++;
        if (overflow !== 1'b0 || out_data !== 9'sd1) begin
            miscompares++;
            $display("FAIL full_push_pop: got ov=%b head=%0d, want ov=0 head=1", overflow, out_data);
        end
        out_ready = 1'b0; pool_in = 9'sd88;
        tick();
        pool_valid = 1'b0;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL full_still_full: got ov=%b, want 1", overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && out_valid; i++) begin
            last_d = out_data; last_r = out_row; last_c = out_col;
            n++;
            tick();
        end
        vectors++;
        if (n != 16 || last_d !== 9'sd77 || last_r !== 5'd1 || last_c !== 5'd2) begin
            miscompares++;
            $display("FAIL full_occupancy: got n=%0d last d=%0d r=%0d c=%0d, want n=16 d=77 r=1 c=2",
                     n, last_d, last_r, last_c);
        end
    endtask

    task automatic test_midframe_reset();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 50; k++) begin
            pool_valid = 1'b1;
            pool_in    = 9'(k);
            tick();
        end
        pool_valid = 1'b0;
        vectors++;
        if (overflow !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre: got ov=%b v=%b, want ov=1 v=1", overflow, out_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 9'sd0) begin
            miscompares++;
            $display("FAIL midreset_clear: got v=%b ov=%b d=%0d, want v=0 ov=0 d=0",
                     out_valid, overflow, out_data);
        end
        out_ready = 1'b1; pool_valid = 1'b1; pool_in = 9'sd50;
        tick();
        pool_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 9'sd50 || out_row !== 5'd0 || out_col !== 5'd0) begin
            miscompares++;
            $display("FAIL midreset_restart: got v=%b d=%0d r=%0d c=%0d, want v=1 d=50 r=0 c=0",
                     out_valid, out_data, out_row, out_col);
        end
    endtask

    task automatic test_relu();
        logic signed [8:0] exp_neg;
`ifdef POOL_COLLECT_RELU_EN
        exp_neg = 9'sd0;
`else
        exp_neg = -9'sd3;
`endif
        apply_reset();
        out_ready = 1'b1; pool_valid = 1'b1; pool_in = -9'sd3;
        tick();
        pool_in = 9'sd7;
        vectors++;
        if (out_data !== exp_neg || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL relu_neg: got d=%0d v=%b, want d=%0d v=1", out_data, out_valid, exp_neg);
        end
        tick();
        pool_valid = 1'b0;
        vectors++;
        if (out_data !== 9'sd7 || out_col !== 5'd1) begin
            miscompares++;
            $display("FAIL relu_pos: got d=%0d c=%0d, want d=7 c=1", out_data, out_col);
        end
    endtask

    initial begin
        reset = 1'b1; pool_valid = 1'b0; pool_in = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_frame();
        test_overflow();
        test_full_push_pop();
        test_midframe_reset();
        test_relu();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
